// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and defaults for the GCD operand loader
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        CLEAR  = 3'd4
    } gcd_state_t;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// rtl/gcd_pair_fifo.sv - small synchronous FIFO holding packed {a,b} operand pairs
module gcd_pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [2*WIDTH-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [2*WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push while full is refused even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gcd_operand_loader.sv
// rtl/gcd_operand_loader.sv - queues operand pairs and sequences them into the GCD core
module gcd_operand_loader
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] op_data,
    output logic             start,
    input  logic             gcd_done,
    output logic             core_clr,
    output logic             busy,
    output logic             err_zero,
    output logic             err_timeout,
    output logic [7:0]       job_cnt
);

    localparam int CW = $clog2(TIMEOUT);

    gcd_state_t         state;
    gcd_state_t         state_nxt;
    logic [CW-1:0]      run_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic               zero_drop;
    logic               timeout_hit;
    logic               job_done;

    assign head_a   = head[2*WIDTH-1:WIDTH];
    assign head_b   = head[WIDTH-1:0];
    assign in_ready = !fifo_full;

    // Zero operands would spin the subtract loop forever, so they never reach the core.
    assign zero_drop   = (state == IDLE) && !fifo_empty && ((head_a == '0) || (head_b == '0));
    assign job_done    = (state == RUN) && gcd_done;
    assign timeout_hit = (state == RUN) && !gcd_done && (run_cnt == CW'(TIMEOUT - 1));
    assign fifo_pop    = (state == CLEAR) || zero_drop;

    gcd_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty && !zero_drop) begin
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: state_nxt = LOAD_B;
            LOAD_B: state_nxt = RUN;
            RUN: begin
                if (job_done || timeout_hit) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_data  = '0;
        start    = 1'b0;
        core_clr = 1'b0;
        busy     = (state != IDLE);
        case (state)
            LOAD_A: begin
                op_data = head_a;
                start   = 1'b1;
            end
            LOAD_B:  op_data = head_b;
            CLEAR:   core_clr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= '0;
            job_cnt     <= '0;
            err_zero    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            run_cnt     <= (state == RUN) ? run_cnt + CW'(1) : '0;
            err_zero    <= zero_drop;
            err_timeout <= timeout_hit;
            if (job_done) begin
                job_cnt <= job_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_operand_loader.sv
// tb/tb_gcd_operand_loader.sv - scoreboard bench with a mock GCD core for gcd_operand_loader
module tb_gcd_operand_loader;
    import gcd_pkg::*;

    localparam int W  = 16;
    localparam int D  = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] op_data;
    logic         start;
    logic         gcd_done = 1'b0;
    logic         core_clr;
    logic         busy;
    logic         err_zero;
    logic         err_timeout;
    logic [7:0]   job_cnt;

    gcd_operand_loader #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .op_data(op_data), .start(start),
        .gcd_done(gcd_done), .core_clr(core_clr), .busy(busy),
        .err_zero(err_zero), .err_timeout(err_timeout), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        gcd_pair_t p;
        int        delay;
        bit        to;
        int        jc;
        int        lat;
    } job_t;

    job_t q[$];
    job_t cur;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   zero_exp = 0;
    int   jc_model = 0;
    int   start_cyc = 0;
    int   last_clr_cyc = -1;
    int   start_count = 0;
    bit   chk_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: pops expected jobs as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_b) begin
                chk("op_b", op_data, cur.p.b);
                chk("start_one_cycle", start, 0);
                chk_b = 1'b0;
            end else if (start) begin
                start_count++;
                if (q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    cur = q[0];
                    chk("op_a", op_data, cur.p.a);
                    start_cyc = cyc;
                    chk_b = 1'b1;
                end
            end else begin
                chk("op_zero_outside_load", op_data, 0);
            end
            if (err_zero) begin
                chk("err_zero_expected", (zero_exp > 0), 1);
                if (zero_exp > 0) zero_exp--;
            end
            if (err_timeout && !core_clr) chk("stray_err_timeout", 1, 0);
            if (core_clr) begin
                if (q.size() == 0) chk("unexpected_core_clr", 1, 0);
                else begin
                    cur = q.pop_front();
                    chk("err_timeout_at_clear", err_timeout, cur.to);
                    chk("job_cnt_at_clear", job_cnt, cur.jc);
                    chk("start_to_clear_latency", cyc - start_cyc, cur.lat);
                    last_clr_cyc = cyc;
                end
            end
        end
    end

    // Mock GCD core: raises done 'delay' cycles after start and holds it until core_clr.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && start && q.size() > 0) begin
                d = q[0].delay;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    gcd_done = 1'b1;
                    for (int k = 0; k < 50 && !core_clr; k++) @(negedge clk);
                    gcd_done = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int delay, output int hs);
        job_t e;
        if (a == 0 || b == 0) zero_exp++;
        else begin
            e.p.a = a;
            e.p.b = b;
            e.delay = delay;
            e.to = (delay == 0);
            if (!e.to) jc_model = (jc_model + 1) % 256;
            e.jc = jc_model;
            e.lat = e.to ? TO + 2 : delay + 1;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        hs = -1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        if (hs < 0) chk("push_accept_timeout", 0, 1);
        else @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && zero_exp == 0 && !busy && !gcd_done) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int hs, hs3, sc;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_clr", core_clr, 0);
        chk("rst_job_cnt", job_cnt, 0);
        chk("rst_errs", {err_zero, err_timeout}, 0);
        rst_n = 1'b1;

        // Single job and handshake-to-start latency
        push(16'd48, 16'd18, 10, hs);
        @(negedge clk);
        chk("t1_no_start_n1", start, 0);
        @(negedge clk);
        chk("t1_start_n2", start, 1);
        chk("t1_start_cycle", cyc, hs + 2);
        wait_idle("t1_done");
        chk("t1_job_cnt", job_cnt, 1);
        chk("t1_busy_low", busy, 0);

        // Zero operand dropped, following pair runs
        push(16'd0, 16'd5, 0, hs);
        push(16'd9, 16'd6, 6, hs);
        wait_idle("t2_done");
        chk("t2_job_cnt", job_cnt, jc_model);

        // Back-pressure with a full FIFO, jobs in order
        push(16'd12, 16'd8, 12, hs);
        push(16'd35, 16'd14, 12, hs);
        @(negedge clk);
        chk("t3_full_in_ready", in_ready, 0);
        push(16'd81, 16'd27, 12, hs3);
        chk("t3_third_after_clear", hs3, last_clr_cyc + 1);
        wait_idle("t3_done");
        chk("t3_job_cnt", job_cnt, jc_model);

        // Timeout with no done
        push(16'd5, 16'd3, 0, hs);
        wait_idle("t4_done");
        chk("t4_job_cnt_unchanged", job_cnt, jc_model);

        // Done on the last counter value beats timeout
        push(16'd14, 16'd21, TO + 1, hs);
        wait_idle("t5_done");
        chk("t5_job_cnt", job_cnt, jc_model);

        // Asynchronous reset during RUN with pairs queued
        push(16'd100, 16'd75, 0, hs);
        push(16'd64, 16'd48, 0, hs);
        repeat (5) @(negedge clk);
        chk("t6_running", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_op", op_data, 0);
        chk("t6_rst_start_clr", {start, core_clr}, 0);
        chk("t6_rst_errs", {err_zero, err_timeout}, 0);
        chk("t6_rst_job_cnt", job_cnt, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        q.delete();
        jc_model = 0;
        zero_exp = 0;
        sc = start_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_no_start_after_release", start_count, sc);
        chk("t6_idle_after_release", busy, 0);
        push(16'd20, 16'd8, 5, hs);
        wait_idle("t6_new_job");
        chk("t6_job_cnt", job_cnt, 1);

        chk("end_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
